// File: rtl/sat_solver_pkg.sv
// Shared SAT-solver types used by the implication queue.
//   NUM_VARIABLE   : number of SAT variables
//   VARIABLE_INDEX : MSB of a variable index
//   var_idx_t      : variable index
//   implication_t  : one implication (variable index plus its implied value)
package sat_solver_pkg;

  localparam int NUM_VARIABLE   = 128;
  localparam int VARIABLE_INDEX = $clog2(NUM_VARIABLE) - 1;

  typedef logic [VARIABLE_INDEX:0] var_idx_t;

  typedef struct packed {
    var_idx_t var_idx;
    logic     val;
  } implication_t;

endpackage

// File: rtl/unit_arbiter.sv
// Fixed-priority one-hot picker: the lowest-index requesting lane wins.
//   en  : when low, no lane is granted
//   req : per-lane request
//   gnt : one-hot grant (all zero if disabled or no request)
module unit_arbiter #(
  parameter int N = 4
) (
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  always_comb begin
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves it unassigned would infer a latch.
    gnt = '0;
    if (en) begin
      // Scan from the top so the lowest requesting lane is written last.
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) begin
          gnt    = '0;
          gnt[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/implication_queue.sv
// Collects unit-clause implications from NUM_EVAL evaluator lanes, filters
// duplicates, detects opposite-polarity implications (conflict) and buffers
// the survivors in a FIFO that hands out one implication per cycle.
//   clk, rst_n        : clock, async active-low reset
//   flush             : synchronous clear on backtrack
//   unit_clause       : per-lane unit flag
//   implied_variable  : per-lane implied variable index
//   new_assignment    : per-lane implied value
//   grant             : one-hot lane consumed this cycle (combinational)
//   out_valid/ready   : head handshake
//   out_var/out_val   : head implication
//   conflict          : sticky conflict flag; conflict_var holds its variable
//   count             : FIFO occupancy
module implication_queue
  import sat_solver_pkg::*;
#(
  parameter int NUM_EVAL = 4,
  parameter int DEPTH    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic     [NUM_EVAL-1:0]    unit_clause,
  input  var_idx_t [NUM_EVAL-1:0]    implied_variable,
  input  logic     [NUM_EVAL-1:0]    new_assignment,
  output logic     [NUM_EVAL-1:0]    grant,
  output logic                       out_valid,
  input  logic                       out_ready,
  output var_idx_t                   out_var,
  output logic                       out_val,
  output logic                       conflict,
  output var_idx_t                   conflict_var,
  output logic     [$clog2(DEPTH):0] count
);

  localparam int            PW   = $clog2(DEPTH);
  localparam logic [PW:0]   FULL = (PW + 1)'(DEPTH);

  implication_t              mem_q [DEPTH];
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]               count_q, count_d;
  logic [NUM_VARIABLE-1:0]   pend_q, pend_d, pval_q, pval_d;
  logic                      conflict_q, conflict_d;
  var_idx_t                  conflict_var_q, conflict_var_d;

  implication_t              cand, head;
  logic                      arb_en, has_cand, enq, deq, conf_hit;

  // A conflict freezes intake; flush and a full FIFO block it too.
  assign arb_en = ~conflict_q & ~flush & (count_q != FULL);

  unit_arbiter #(.N(NUM_EVAL)) u_arb (
    .en  (arb_en),
    .req (unit_clause),
    .gnt (grant)
  );

  // One-hot select of the granted lane.
  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_EVAL; i++) begin
      if (grant[i]) begin
        cand.var_idx = implied_variable[i];
        cand.val     = new_assignment[i];
      end
    end
  end

  // Lookups use registered state, so a variable leaving the head this cycle
  // still counts as pending for the incoming candidate.
  assign has_cand = |grant;
  assign enq      = has_cand & ~pend_q[cand.var_idx];
  assign conf_hit = has_cand & pend_q[cand.var_idx] & (pval_q[cand.var_idx] != cand.val);

  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0) & ~conflict_q;
  assign deq       = out_valid & out_ready & ~flush;

  assign out_var      = head.var_idx;
  assign out_val      = head.val;
  assign conflict     = conflict_q;
  assign conflict_var = conflict_var_q;
  assign count        = count_q;

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    pend_d         = pend_q;
    pval_d         = pval_q;
    conflict_d     = conflict_q;
    conflict_var_d = conflict_var_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      pend_d     = '0;
      pval_d     = '0;
      conflict_d = 1'b0;
    end else begin
      // Dequeue clears first; an enqueue never targets the same variable
      // because that variable is still pending in registered state.
      if (deq) begin
        rd_ptr_d              = rd_ptr_q + PW'(1);
        pend_d[head.var_idx]  = 1'b0;
      end
      if (enq) begin
        wr_ptr_d              = wr_ptr_q + PW'(1);
        pend_d[cand.var_idx]  = 1'b1;
        pval_d[cand.var_idx]  = cand.val;
      end
      if (conf_hit) begin
        conflict_d     = 1'b1;
        conflict_var_d = cand.var_idx;
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + (PW + 1)'(1);
        2'b01:   count_d = count_q - (PW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      pend_q         <= '0;
      pval_q         <= '0;
      conflict_q     <= 1'b0;
      conflict_var_q <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      pend_q         <= pend_d;
      pval_q         <= pval_d;
      conflict_q     <= conflict_d;
      conflict_var_q <= conflict_var_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count and pointers
  // already mark every slot invalid, so resetting it would only cost flops.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= cand;
  end

endmodule

// File: tb/tb_implication_queue.sv
module tb_implication_queue;

  localparam int NE    = 4;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic [NE-1:0]   unit_clause;
  logic [NE-1:0][6:0] implied_variable;
  logic [NE-1:0]   new_assignment;
  logic [NE-1:0]   grant;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      out_var;
  logic            out_val;
  logic            conflict;
  logic [6:0]      conflict_var;
  logic [4:0]      count;

  implication_queue #(.NUM_EVAL(NE), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .unit_clause      (unit_clause),
    .implied_variable (implied_variable),
    .new_assignment   (new_assignment),
    .grant            (grant),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_var          (out_var),
    .out_val          (out_val),
    .conflict         (conflict),
    .conflict_var     (conflict_var),
    .count            (count)
  );

  always #5 clk = ~clk;

  // Reference model: an ordered list of queued implications plus conflict.
  typedef struct { int v; bit b; } ent_t;
  ent_t q[$];
  bit   m_conf;
  int   m_conf_var;

  logic [NE-1:0] exp_grant;
  bit            exp_valid;
  int            exp_count;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic clear_lanes();
    unit_clause      = '0;
    implied_variable = '0;
    new_assignment   = '0;
  endtask

  task automatic set_lane(input int i, input int v, input bit b);
    unit_clause[i]      = 1'b1;
    implied_variable[i] = 7'(v);
    new_assignment[i]   = b;
  endtask

  task automatic model_reset();
    q.delete();
    m_conf     = 1'b0;
    m_conf_var = 0;
  endtask

  // Expected outputs for the current inputs and model state.
  task automatic predict();
    bit found;
    found     = 1'b0;
    exp_count = q.size();
    exp_valid = (q.size() != 0) && !m_conf;
    exp_grant = '0;
    if (!flush && !m_conf && q.size() < DEPTH) begin
      for (int i = 0; i < NE; i++) begin
        if (unit_clause[i] && !found) begin
          exp_grant[i] = 1'b1;
          found        = 1'b1;
        end
      end
    end
  endtask

  task automatic settle();
    #1;
    predict();
  endtask

  // One clock edge: DUT and model both advance; returns just after negedge.
  task automatic advance();
    int gi, idx, v;
    bit b, deq, fl;
    predict();
    gi = -1;
    for (int i = 0; i < NE; i++) if (exp_grant[i] && gi < 0) gi = i;
    deq = exp_valid && out_ready;
    fl  = flush;
    if (gi >= 0) begin
      v = int'(implied_variable[gi]);
      b = new_assignment[gi];
    end else begin
      v = 0;
      b = 1'b0;
    end
    @(posedge clk);
    if (fl) begin
      q.delete();
      m_conf = 1'b0;
    end else begin
      if (gi >= 0) begin
        idx = -1;
        foreach (q[k]) if (q[k].v == v) idx = k;
        if (idx < 0) q.push_back('{v: v, b: b});
        else if (q[idx].b != b) begin
          m_conf     = 1'b1;
          m_conf_var = v;
        end
      end
      if (deq) void'(q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic do_flush();
    clear_lanes();
    out_ready = 1'b0;
    flush     = 1'b1;
    advance();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    clear_lanes();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (count !== 5'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (conflict !== 1'b0) $display("FAIL reset_conflict: got %b want 0", conflict); else n_pass++;
    n_checks++; if (conflict_var !== 7'd0) $display("FAIL reset_conflict_var: got %0d want 0", conflict_var); else n_pass++;
    n_checks++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", grant); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    set_lane(0, 5, 1'b1);
    settle();
    n_checks++; if (grant !== 4'b0001) $display("FAIL single_grant: got %b want 0001", grant); else n_pass++;
    advance();
    clear_lanes();
    settle();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_var !== 7'd5 || out_val !== 1'b1)
      $display("FAIL single_head: got var %0d val %b want var 5 val 1", out_var, out_val); else n_pass++;
    n_checks++; if (count !== 5'd1) $display("FAIL single_count: got %0d want 1", count); else n_pass++;
    out_ready = 1'b1;
    advance();
    out_ready = 1'b0;
    settle();
    n_checks++; if (count !== 5'd0 || out_valid !== 1'b0)
      $display("FAIL single_drain: got count %0d valid %b want 0 0", count, out_valid); else n_pass++;
  endtask

  task automatic test_priority();
    set_lane(1, 7, 1'b0);
    set_lane(3, 9, 1'b1);
    settle();
    n_checks++; if (grant !== 4'b0010) $display("FAIL prio_grant: got %b want 0010", grant); else n_pass++;
    advance();
    unit_clause[1] = 1'b0;
    settle();
    n_checks++; if (grant !== 4'b1000) $display("FAIL prio_grant_next: got %b want 1000", grant); else n_pass++;
    advance();
    clear_lanes();
    settle();
    n_checks++; if (count !== 5'd2 || out_var !== 7'd7 || out_val !== 1'b0)
      $display("FAIL prio_queue: got count %0d head %0d/%b want 2 7/0", count, out_var, out_val); else n_pass++;
    do_flush();
  endtask

  task automatic test_duplicate();
    set_lane(0, 5, 1'b1);
    advance();
    settle();
    n_checks++; if (grant !== 4'b0001) $display("FAIL dup_grant: got %b want 0001", grant); else n_pass++;
    advance();
    clear_lanes();
    settle();
    n_checks++; if (count !== 5'd1 || conflict !== 1'b0)
      $display("FAIL dup_count: got count %0d conflict %b want 1 0", count, conflict); else n_pass++;
    do_flush();
  endtask

  task automatic test_conflict();
    set_lane(0, 5, 1'b1);
    advance();
    clear_lanes();
    set_lane(2, 5, 1'b0);
    settle();
    n_checks++; if (grant !== 4'b0100) $display("FAIL conf_grant: got %b want 0100", grant); else n_pass++;
    advance();
    clear_lanes();
    settle();
    n_checks++; if (conflict !== 1'b1 || conflict_var !== 7'd5)
      $display("FAIL conf_flag: got %b var %0d want 1 var 5", conflict, conflict_var); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL conf_valid: got %b want 0", out_valid); else n_pass++;
    set_lane(0, 11, 1'b0);
    out_ready = 1'b1;
    settle();
    n_checks++; if (grant !== 4'b0000) $display("FAIL conf_frozen_grant: got %b want 0000", grant); else n_pass++;
    advance();
    settle();
    n_checks++; if (count !== 5'd1 || conflict !== 1'b1)
      $display("FAIL conf_frozen: got count %0d conflict %b want 1 1", count, conflict); else n_pass++;
    flush = 1'b1;
    settle();
    n_checks++; if (grant !== 4'b0000) $display("FAIL flush_grant: got %b want 0000", grant); else n_pass++;
    advance();
    flush = 1'b0;
    out_ready = 1'b0;
    clear_lanes();
    settle();
    n_checks++; if (conflict !== 1'b0 || count !== 5'd0)
      $display("FAIL flush_clear: got conflict %b count %0d want 0 0", conflict, count); else n_pass++;
  endtask

  task automatic test_full_wrap();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      clear_lanes();
      set_lane(0, 20 + i, i[0]);
      advance();
    end
    clear_lanes();
    set_lane(0, 50, 1'b1);
    settle();
    n_checks++; if (count !== 5'd16) $display("FAIL full_count: got %0d want 16", count); else n_pass++;
    n_checks++; if (grant !== 4'b0000) $display("FAIL full_grant: got %b want 0000", grant); else n_pass++;
    clear_lanes();
    out_ready = 1'b1;
    advance();
    set_lane(0, 60, 1'b1);
    settle();
    n_checks++; if (grant !== 4'b0001 || out_var !== 7'd21)
      $display("FAIL wrap_enq: got grant %b head %0d want 0001 21", grant, out_var); else n_pass++;
    advance();
    clear_lanes();
    settle();
    n_checks++; if (count !== 5'd15) $display("FAIL wrap_count: got %0d want 15", count); else n_pass++;
    for (int k = 0; k < 15; k++) begin
      int want_v;
      bit want_b;
      want_v = (k < 14) ? 22 + k : 60;
      want_b = (k < 14) ? 1'((22 + k) % 2 == 1) : 1'b1;
      settle();
      n_checks++; if (out_valid !== 1'b1 || out_var !== 7'(want_v) || out_val !== want_b)
        $display("FAIL wrap_order[%0d]: got %b %0d/%b want 1 %0d/%b", k, out_valid, out_var, out_val, want_v, want_b);
      else n_pass++;
      advance();
    end
    out_ready = 1'b0;
    settle();
    n_checks++; if (count !== 5'd0) $display("FAIL wrap_empty: got %0d want 0", count); else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      clear_lanes();
      for (int i = 0; i < NE; i++)
        if ($urandom_range(0, 2) == 0) set_lane(i, $urandom_range(0, 15), 1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = m_conf ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
      settle();
      n_checks++;
      if (grant !== exp_grant || out_valid !== exp_valid || count !== 5'(exp_count) || conflict !== m_conf)
        $display("FAIL rand_outputs[%0d]: got g%b v%b c%0d x%b want g%b v%b c%0d x%b", c,
                 grant, out_valid, count, conflict, exp_grant, exp_valid, exp_count, m_conf);
      else n_pass++;
      if (exp_valid) begin
        n_checks++;
        if (out_var !== 7'(q[0].v) || out_val !== q[0].b)
          $display("FAIL rand_head[%0d]: got %0d/%b want %0d/%b", c, out_var, out_val, q[0].v, q[0].b);
        else n_pass++;
      end
      if (m_conf) begin
        n_checks++;
        if (conflict_var !== 7'(m_conf_var))
          $display("FAIL rand_conflict_var[%0d]: got %0d want %0d", c, conflict_var, m_conf_var);
        else n_pass++;
      end
      advance();
    end
    flush = 1'b0;
    do_flush();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      clear_lanes();
      set_lane(i % NE, 40 + i, 1'b1);
      advance();
    end
    clear_lanes();
    settle();
    n_checks++; if (count !== 5'd8) $display("FAIL midrst_fill: got %0d want 8", count); else n_pass++;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++; if (count !== 5'd0 || out_valid !== 1'b0)
      $display("FAIL midrst_async: got count %0d valid %b want 0 0", count, out_valid); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    set_lane(0, 3, 1'b0);
    settle();
    n_checks++; if (grant !== 4'b0001) $display("FAIL midrst_grant: got %b want 0001", grant); else n_pass++;
    advance();
    clear_lanes();
    settle();
    n_checks++; if (out_valid !== 1'b1 || out_var !== 7'd3 || out_val !== 1'b0 || count !== 5'd1)
      $display("FAIL midrst_enq: got %b %0d/%b c%0d want 1 3/0 c1", out_valid, out_var, out_val, count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_duplicate();
    test_conflict();
    test_full_wrap();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
